// File: rtl/adc_serial_emulator.sv
// Stand-in for the ADCXX1S101 serial ADC: answers cs_n/sclk frames from the
// pixel ADC controller with 12-bit words taken from a selectable test pattern.
module adc_serial_emulator #(
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned LEAD_ZEROS = 3,
    parameter int unsigned LINE_LEN   = 112,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 cs_ni,
    input  logic                 sclk_i,
    input  logic [1:0]           mode_i,
    input  logic [DATA_BITS-1:0] const_value_i,
    input  logic [DATA_BITS-1:0] ramp_step_i,
    input  logic                 newline_i,
    input  logic [DATA_BITS-1:0] stream_data_i,
    input  logic                 stream_valid_i,
    output logic                 stream_ready_o,
    input  logic                 clear_status_i,
    output logic                 sdata_o,
    output logic                 sdata_oe_o,
    output logic                 busy_o,
    output logic [CNT_BITS-1:0]  conv_count_o,
    output logic                 underrun_o,
    output logic                 abort_err_o
);

    localparam int unsigned FrameBits = LEAD_ZEROS + DATA_BITS;
    localparam int unsigned KW        = $clog2(FrameBits + 1);
    localparam int unsigned PW        = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StTail} state_e;

    state_e                state_q;
    logic                  cs_q, sclk_q;
    logic [KW-1:0]         k_q;
    logic [DATA_BITS-1:0]  word_q;
    logic [PW-1:0]         pix_q;
    logic [DATA_BITS-1:0]  hold_q;
    logic                  hold_full_q;
    logic                  phase_q;
    logic                  sdata_q, sdata_oe_q, busy_q;
    logic [CNT_BITS-1:0]   conv_q;
    logic                  underrun_q, abort_q;

    logic                  cs_fall, sclk_fall, start;
    logic                  is_stream;
    logic [DATA_BITS-1:0]  ramp_word, word_sel;
    logic                  take_hold, set_under;
    logic [KW-1:0]         k_inc;
    logic [PW-1:0]         pix_next;
    logic [CNT_BITS-1:0]   conv_base;
    logic                  under_base, abort_base;

    // Frame bit k of word w: leading zeros, then MSB-first data, then zeros.
    function automatic logic frame_bit(input logic [KW-1:0] k, input logic [DATA_BITS-1:0] w);
        int unsigned          kk;
        logic [DATA_BITS-1:0] s;
        kk = 32'(k);
        s  = w << (kk - LEAD_ZEROS);
        if (kk >= LEAD_ZEROS && kk < FrameBits) return s[DATA_BITS-1];
        return 1'b0;
    endfunction

    assign cs_fall   = cs_q & ~cs_ni;
    assign sclk_fall = sclk_q & ~sclk_i & ~cs_ni;
    assign start     = cs_fall && (state_q == StIdle);
    assign is_stream = (mode_i == 2'd2);
    assign ramp_word = ramp_step_i * DATA_BITS'(pix_q);
    assign k_inc     = (k_q == KW'(FrameBits)) ? k_q : k_q + 1'b1;
    assign pix_next  = (pix_q == PW'(LINE_LEN - 1)) ? '0 : pix_q + 1'b1;

    // clear_status acts before any same-cycle increment or sticky set.
    assign conv_base  = clear_status_i ? '0 : conv_q;
    assign under_base = clear_status_i ? 1'b0 : underrun_q;
    assign abort_base = clear_status_i ? 1'b0 : abort_q;

    // Pattern word offered at a conversion start; flags say where it came from.
    always_comb begin
        word_sel  = const_value_i;
        take_hold = 1'b0;
        set_under = 1'b0;
        case (mode_i)
            2'd0: word_sel = const_value_i;
            2'd1: word_sel = ramp_word;
            2'd2: begin
                if (hold_full_q) begin
                    word_sel  = hold_q;
                    take_hold = 1'b1;
                end else if (stream_valid_i) begin
                    word_sel = stream_data_i;
                end else begin
                    word_sel  = word_q;
                    set_under = 1'b1;
                end
            end
            2'd3: word_sel = phase_q ? ~const_value_i : const_value_i;
        endcase
    end

    // Previous cs_n/sclk levels for edge detection; idle levels are high.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cs_q   <= 1'b1;
            sclk_q <= 1'b1;
        end else begin
            cs_q   <= cs_ni;
            sclk_q <= sclk_i;
        end
    end

    // Ramp pixel index, alternating phase and the depth-1 stream holding register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pix_q       <= '0;
            phase_q     <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            if (newline_i) begin
                pix_q <= '0;
            end else if (start && mode_i == 2'd1) begin
                pix_q <= pix_next;
            end
            // Phase advances only on alternating-mode conversions.
            if (start && mode_i == 2'd3) begin
                phase_q <= ~phase_q;
            end
            if (start && is_stream && take_hold) begin
                hold_full_q <= 1'b0;
            end else if (stream_valid_i && !hold_full_q && !(start && is_stream)) begin
                // A sample offered during a stream conversion start is bypassed, not stored.
                hold_q      <= stream_data_i;
                hold_full_q <= 1'b1;
            end
        end
    end

    // Frame state machine with registered serial output and status.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            k_q        <= '0;
            word_q     <= '0;
            sdata_q    <= 1'b0;
            sdata_oe_q <= 1'b0;
            busy_q     <= 1'b0;
            conv_q     <= '0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            sdata_oe_q <= ~cs_ni;
            conv_q     <= conv_base;
            underrun_q <= under_base | (start & is_stream & set_under);
            abort_q    <= abort_base | ((state_q == StShift) & cs_ni);
            case (state_q)
                StIdle: begin
                    sdata_q <= 1'b0;
                    if (start) begin
                        state_q <= StShift;
                        k_q     <= '0;
                        word_q  <= word_sel;
                        busy_q  <= 1'b1;
                        sdata_q <= frame_bit('0, word_sel);
                        conv_q  <= conv_base + 1'b1;
                    end
                end
                StShift, StTail: begin
                    if (cs_ni) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        sdata_q <= 1'b0;
                    end else if (sclk_fall) begin
                        k_q     <= k_inc;
                        sdata_q <= frame_bit(k_inc, word_q);
                        if (k_inc == KW'(FrameBits)) state_q <= StTail;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sdata_o        = sdata_q;
    assign sdata_oe_o     = sdata_oe_q;
    assign busy_o         = busy_q;
    assign conv_count_o   = conv_q;
    assign underrun_o     = underrun_q;
    assign abort_err_o    = abort_q;
    assign stream_ready_o = ~hold_full_q;

endmodule
